axis_crop_window_ctrl: RTL and testbench

Frame-synchronous controller for the video crop window in the capture path. Holds the active crop offsets that feed the runtime crop stage, takes new offsets from the control side through a valid/ready port, clamps them to the legal range, and applies them only at a frame boundary so every output frame uses one window. Optionally auto-pans the window by a signed step per frame. Frame boundaries come from snooping the crop stage's input AXIS handshake.

---
 rtl/axis_crop_window_ctrl.sv | 167 ++++++++++++++++
 tb/tb_axis_crop_window_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_crop_window_ctrl.sv
// Frame-synchronous crop window controller: shadows clamped offset requests from the
// control side and applies them (or an auto-pan step) at frame boundaries seen on a snooped AXIS.
module axis_crop_window_ctrl #(
  parameter int VIDEO_IN_W    = 1920,
  parameter int VIDEO_IN_H    = 1080,
  parameter int VIDEO_OUT_W   = 640,
  parameter int VIDEO_OUT_H   = 480,
  parameter int INIT_H_OFFSET = 640,
  parameter int INIT_V_OFFSET = 300
) (
  input  logic        axis_clk,
  input  logic        aresetn,
  input  logic        mon_tvalid,
  input  logic        mon_tready,
  input  logic        mon_tuser,
  input  logic        mon_tlast,
  input  logic [15:0] cfg_h_offset,
  input  logic [15:0] cfg_v_offset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        pan_en,
  input  logic [7:0]  pan_dx,
  input  logic [7:0]  pan_dy,
  output logic [15:0] crop_h_offset,
  output logic [15:0] crop_v_offset,
  output logic        crop_update,
  output logic        cfg_pending,
  output logic        cfg_clamped,
  output logic        resync_err,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] H_MAX     = 16'(VIDEO_IN_W - VIDEO_OUT_W);
  localparam logic [15:0] V_MAX     = 16'(VIDEO_IN_H - VIDEO_OUT_H);
  localparam logic [15:0] LAST_LINE = 16'(VIDEO_IN_H - 1);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] line_q, line_d;
  logic [15:0] shadow_h_q, shadow_h_d, shadow_v_q, shadow_v_d;
  logic [15:0] crop_h_q, crop_h_d, crop_v_q, crop_v_d;
  logic [15:0] frame_q, frame_d;
  logic        update_q, update_d;
  logic        ready_q, ready_d;
  logic        pending_q, pending_d;
  logic        clamped_q, clamped_d;
  logic        resync_q, resync_d;
  logic        beat, eof, resync, boundary, accept;

  function automatic logic [15:0] clamp_max(input logic [15:0] val, input logic [15:0] max);
    return (val > max) ? max : val;
  endfunction

  // Signed step is added in 18 bits so both underflow below 0 and overflow above max saturate.
  function automatic logic [15:0] pan_sat(input logic [15:0] cur, input logic [7:0] step,
                                          input logic [15:0] max);
    logic signed [17:0] sum;
    sum = $signed({2'b00, cur}) + $signed({{10{step[7]}}, step});
    if (sum < 18'sd0) begin
      return 16'd0;
    end else if (sum > $signed({2'b00, max})) begin
      return max;
    end else begin
      return sum[15:0];
    end
  endfunction

  assign beat     = mon_tvalid & mon_tready;
  assign eof      = beat & mon_tlast & (line_q == LAST_LINE);
  assign resync   = beat & mon_tuser & (line_q != 16'd0);
  assign boundary = eof | resync;
  assign accept   = cfg_valid & ready_q;

  always_comb begin
    line_d     = line_q;
    state_d    = state_q;
    shadow_h_d = shadow_h_q;
    shadow_v_d = shadow_v_q;
    crop_h_d   = crop_h_q;
    crop_v_d   = crop_v_q;
    clamped_d  = clamped_q;
    if (boundary) begin
      line_d = 16'd0;
    end else if (beat & mon_tlast) begin
      line_d = line_q + 16'd1;
    end else begin
      line_d = line_q;
    end
    case (state_q)
      IDLE: begin
        // A request accepted on a boundary edge is shadowed; this boundary still pans.
        if (boundary && pan_en) begin
          crop_h_d = pan_sat(crop_h_q, pan_dx, H_MAX);
          crop_v_d = pan_sat(crop_v_q, pan_dy, V_MAX);
        end else begin
          crop_h_d = crop_h_q;
          crop_v_d = crop_v_q;
        end
        if (accept) begin
          shadow_h_d = clamp_max(cfg_h_offset, H_MAX);
          shadow_v_d = clamp_max(cfg_v_offset, V_MAX);
          clamped_d  = (cfg_h_offset > H_MAX) | (cfg_v_offset > V_MAX);
          state_d    = PEND;
        end else begin
          state_d = IDLE;
        end
      end
      PEND: begin
        if (boundary) begin
          crop_h_d = shadow_h_q;
          crop_v_d = shadow_v_q;
          state_d  = IDLE;
        end else begin
          state_d = PEND;
        end
      end
      default: state_d = IDLE;
    endcase
    update_d  = boundary & ((crop_h_d != crop_h_q) | (crop_v_d != crop_v_q));
    ready_d   = (state_d == IDLE);
    pending_d = (state_d == PEND);
    resync_d  = resync_q | resync;
    frame_d   = boundary ? (frame_q + 16'd1) : frame_q;
  end

  // State and registered outputs.
  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      line_q     <= 16'd0;
      shadow_h_q <= 16'(INIT_H_OFFSET);
      shadow_v_q <= 16'(INIT_V_OFFSET);
      crop_h_q   <= 16'(INIT_H_OFFSET);
      crop_v_q   <= 16'(INIT_V_OFFSET);
      frame_q    <= 16'd0;
      update_q   <= 1'b0;
      ready_q    <= 1'b1;
      pending_q  <= 1'b0;
      clamped_q  <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      shadow_h_q <= shadow_h_d;
      shadow_v_q <= shadow_v_d;
      crop_h_q   <= crop_h_d;
      crop_v_q   <= crop_v_d;
      frame_q    <= frame_d;
      update_q   <= update_d;
      ready_q    <= ready_d;
      pending_q  <= pending_d;
      clamped_q  <= clamped_d;
      resync_q   <= resync_d;
    end
  end

  assign cfg_ready     = ready_q;
  assign crop_h_offset = crop_h_q;
  assign crop_v_offset = crop_v_q;
  assign crop_update   = update_q;
  assign cfg_pending   = pending_q;
  assign cfg_clamped   = clamped_q;
  assign resync_err    = resync_q;
  assign frame_cnt     = frame_q;

endmodule

// File: tb/tb_axis_crop_window_ctrl.sv
// Randomised bench for axis_crop_window_ctrl: frame-level reference model feeding a
// boundary scoreboard, plus per-cycle comparison of the visible window state.
module tb_axis_crop_window_ctrl;

  localparam int IN_H  = 1080;
  localparam int H_MAX = 1280;
  localparam int V_MAX = 600;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        mon_tvalid, mon_tready, mon_tuser, mon_tlast;
  logic [15:0] cfg_h, cfg_v;
  logic        cfg_valid, cfg_ready;
  logic        pan_en;
  logic [7:0]  pan_dx, pan_dy;
  logic [15:0] crop_h, crop_v, frame_cnt;
  logic        crop_update, cfg_pending, cfg_clamped, resync_err;

  axis_crop_window_ctrl dut (
    .axis_clk(clk), .aresetn(aresetn),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tuser(mon_tuser), .mon_tlast(mon_tlast),
    .cfg_h_offset(cfg_h), .cfg_v_offset(cfg_v), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .pan_en(pan_en), .pan_dx(pan_dx), .pan_dy(pan_dy),
    .crop_h_offset(crop_h), .crop_v_offset(crop_v), .crop_update(crop_update),
    .cfg_pending(cfg_pending), .cfg_clamped(cfg_clamped), .resync_err(resync_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int fc;
    bit upd;
    bit err;
  } bnd_t;
  bnd_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit run      = 1'b0;
  bit rnd_mode = 1'b0;
  int seen_fc  = 0;

  // reference model state
  int m_h = 640, m_v = 300, m_sh = 640, m_sv = 300, m_lc = 0, m_fc = 0;
  bit m_pend = 0, m_clamp = 0, m_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int val, input int max);
    if (val < 0) return 0;
    if (val > max) return max;
    return val;
  endfunction

  // Apply the behavioural rules to the inputs that were present at the edge just taken.
  task automatic model_edge();
    bit beat, eof, rs, bnd, acc, chg;
    int oh, ov, dx, dy;
    bnd_t e;
    beat = mon_tvalid & mon_tready;
    eof  = beat && mon_tlast && (m_lc == IN_H - 1);
    rs   = beat && mon_tuser && (m_lc != 0);
    bnd  = eof | rs;
    if (bnd) m_lc = 0;
    else if (beat && mon_tlast) m_lc++;
    acc = cfg_valid && !m_pend;
    oh = m_h;
    ov = m_v;
    if (bnd) begin
      if (m_pend) begin
        m_h = m_sh;
        m_v = m_sv;
        m_pend = 0;
      end else if (pan_en) begin
        dx = $signed(pan_dx);
        dy = $signed(pan_dy);
        m_h = sat(m_h + dx, H_MAX);
        m_v = sat(m_v + dy, V_MAX);
      end
      chg   = (m_h != oh) || (m_v != ov);
      m_fc  = (m_fc + 1) % 65536;
      m_err = m_err | rs;
      e.fc = m_fc; e.upd = chg; e.err = m_err;
      sb.push_back(e);
    end
    if (acc) begin
      m_sh    = (cfg_h > H_MAX) ? H_MAX : int'(cfg_h);
      m_sv    = (cfg_v > V_MAX) ? V_MAX : int'(cfg_v);
      m_clamp = (cfg_h > H_MAX) || (cfg_v > V_MAX);
      m_pend  = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_cfg();
    if (rnd_mode) begin
      cfg_valid = ($urandom_range(0, 150) == 0);
      cfg_h     = 16'($urandom_range(0, 2000));
      cfg_v     = 16'($urandom_range(0, 900));
    end
  endtask

  task automatic send_beat(input bit user, input bit last);
    int  tries = 0;
    bit  hs;
    mon_tvalid = 1'b1;
    mon_tuser  = user;
    mon_tlast  = last;
    do begin
      mon_tready = (tries >= 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
      hs = mon_tready;
      rand_cfg();
      tick();
      tries++;
    end while (!hs);
    mon_tvalid = 1'b0;
    mon_tuser  = 1'b0;
    mon_tlast  = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      mon_tready = $urandom_range(0, 1);
      rand_cfg();
      tick();
    end
  endtask

  // The SOF line always has two beats so the SOF beat never also ends a line.
  task automatic send_lines(input int n, input bit sof);
    int nb;
    for (int i = 0; i < n; i++) begin
      nb = (i == 0 && sof) ? 2 : 1 + $urandom_range(0, 1);
      for (int b = 0; b < nb; b++) send_beat(sof && i == 0 && b == 0, b == nb - 1);
    end
  endtask

  task automatic send_frame();
    send_lines(IN_H, 1'b1);
  endtask

  task automatic send_cfg(input int h, input int v);
    cfg_h = 16'(h);
    cfg_v = 16'(v);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Monitor: pops one expectation per observed boundary and tracks the visible window every cycle.
  always @(negedge clk) begin
    if (run) begin
      if (int'(frame_cnt) != seen_fc) begin
        seen_fc = frame_cnt;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_boundary: frame_cnt %0d with empty scoreboard", frame_cnt);
        end else begin
          bnd_t e;
          e = sb.pop_front();
          chk("bnd_frame_cnt", frame_cnt, e.fc);
          chk("bnd_crop_update", crop_update, e.upd);
          chk("bnd_resync_err", resync_err, e.err);
        end
      end else begin
        chk("idle_crop_update", crop_update, 0);
      end
      chk("crop_h", crop_h, m_h);
      chk("crop_v", crop_v, m_v);
      chk("cfg_ready", cfg_ready, !m_pend);
      chk("cfg_pending", cfg_pending, m_pend);
      chk("cfg_clamped", cfg_clamped, m_clamp);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc0;
    aresetn = 1'b0;
    mon_tvalid = 0; mon_tready = 0; mon_tuser = 0; mon_tlast = 0;
    cfg_h = 0; cfg_v = 0; cfg_valid = 0; pan_en = 0; pan_dx = 0; pan_dy = 0;
    #12;
    chk("rst_crop_h", crop_h, 640);
    chk("rst_crop_v", crop_v, 300);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cfg_pending", cfg_pending, 0);
    chk("rst_crop_update", crop_update, 0);
    chk("rst_cfg_clamped", cfg_clamped, 0);
    chk("rst_resync_err", resync_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    #11;
    aresetn = 1'b1;
    run = 1'b1;

    // basic apply at EOF
    send_cfg(100, 50);
    send_frame();
    tick();
    chk("t1_h", crop_h, 100);
    chk("t1_v", crop_v, 50);
    chk("t1_fc", frame_cnt, 1);
    chk("t1_ready", cfg_ready, 1);

    // clamping
    send_cfg(2000, 700);
    chk("t2_clamped", cfg_clamped, 1);
    send_frame();
    chk("t2_h", crop_h, 1280);
    chk("t2_v", crop_v, 600);
    send_cfg(10, 10);
    chk("t2_unclamped", cfg_clamped, 0);
    send_frame();

    // auto-pan saturating at both ends
    send_cfg(1276, 4);
    send_frame();
    pan_en = 1; pan_dx = 8'd8; pan_dy = 8'hF8;
    send_frame();
    chk("t3_h1", crop_h, 1280);
    chk("t3_v1", crop_v, 0);
    send_frame();
    chk("t3_h2", crop_h, 1280);
    chk("t3_v2", crop_v, 0);
    pan_en = 0;

    // SOF mid-frame while pending
    send_cfg(200, 100);
    send_lines(500, 1'b1);
    send_frame();
    chk("t4_resync_err", resync_err, 1);
    chk("t4_h", crop_h, 200);
    chk("t4_v", crop_v, 100);

    // stalled final tlast
    send_cfg(300, 200);
    send_lines(IN_H - 1, 1'b1);
    fc0 = frame_cnt;
    mon_tvalid = 1; mon_tlast = 1; mon_tuser = 0; mon_tready = 0;
    repeat (10) tick();
    chk("t5_stall_fc", frame_cnt, fc0);
    chk("t5_stall_h", crop_h, 200);
    mon_tready = 1;
    tick();
    mon_tvalid = 0; mon_tlast = 0;
    tick();
    chk("t5_done_fc", frame_cnt, (fc0 + 1) % 65536);
    chk("t5_done_h", crop_h, 300);

    // cfg accepted on the EOF edge while panning
    send_cfg(0, 0);
    send_frame();
    pan_en = 1; pan_dx = 8'd4; pan_dy = 8'd0;
    send_lines(IN_H - 1, 1'b1);
    cfg_h = 50; cfg_v = 60; cfg_valid = 1;
    mon_tvalid = 1; mon_tlast = 1; mon_tready = 1;
    tick();
    cfg_valid = 0; mon_tvalid = 0; mon_tlast = 0;
    tick();
    chk("t6_pan_h", crop_h, 4);
    chk("t6_pan_v", crop_v, 0);
    chk("t6_pending", cfg_pending, 1);
    send_frame();
    chk("t6_apply_h", crop_h, 50);
    chk("t6_apply_v", crop_v, 60);
    pan_en = 0;

    // random requests, pan steps and stream timing
    rnd_mode = 1;
    for (int f = 0; f < 4; f++) begin
      pan_en = $urandom_range(0, 1);
      pan_dx = 8'($urandom_range(0, 255));
      pan_dy = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) send_lines($urandom_range(10, 300), 1'b1);
      send_frame();
    end
    rnd_mode = 0;
    cfg_valid = 0;
    repeat (5) tick();
    chk("sb_drained", sb.size(), 0);
    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
